// File: rtl/input_stall_controller_pkg.sv
// Shared processor definitions used by the IN-instruction stall logic:
// the default data-word width and the 2-bit FSM state encoding.
package input_stall_controller_pkg;

  localparam int DATA_W_DEF = 16;

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_WAIT_PRESS   = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;
  localparam logic [1:0] ST_DONE         = 2'd3;

endpackage

// File: rtl/input_debouncer.sv
// Board key conditioning: 2-flop synchronizer, polarity normalisation
// (pressed=1) and a stable-level debouncer that emits single-cycle
// press/release event pulses in the cycle the stable level flips.
module input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic press_evt_o,
  output logic release_evt_o
);

  localparam int                CNT_W        = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic              RAW_RELEASED = BTN_ACTIVE_LOW;
  localparam logic [CNT_W-1:0]  CNT_MAX      = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed;
  logic             flip;

  // Two-stage synchronizer; resets to the raw released level so no event fires out of reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= RAW_RELEASED;
      sync2_q <= RAW_RELEASED;
    end else begin
      sync1_q <= button_i;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = sync2_q ^ BTN_ACTIVE_LOW;

  // Count consecutive cycles of disagreement; flip the stable level at the terminal count
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    flip     = 1'b0;
    if (pressed != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        flip     = 1'b1;
        stable_d = pressed;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign press_evt_o   = flip & pressed;
  assign release_evt_o = flip & ~pressed;

endmodule

// File: rtl/input_stall_controller.sv
// Responder side of the PC stall interface for IN instructions: stalls the
// PC while waiting for a debounced key press/release, captures the switch
// word on the press, and releases the stall for exactly one cycle.
module input_stall_controller
  import input_stall_controller_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_req,
  input  logic              hlt,
  input  logic              button,
  input  logic [DATA_W-1:0] switches,
  output logic              insign,
  output logic [DATA_W-1:0] in_data,
  output logic              in_valid,
  output logic              busy
);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] in_data_q, in_data_d;
  logic              capture;
  logic              press_evt, release_evt;

  input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debouncer (
    .clk_i         (clock),
    .rst_ni        (reset),
    .button_i      (button),
    .press_evt_o   (press_evt),
    .release_evt_o (release_evt)
  );

  // Next-state logic; hlt and a dropped in_req both abort back to IDLE without capturing
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (hlt || !in_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:         state_d = ST_WAIT_PRESS;
        ST_WAIT_PRESS: begin
          if (press_evt) begin
            capture = 1'b1;
            state_d = ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: if (release_evt) state_d = ST_DONE;
        ST_DONE:         state_d = ST_IDLE;
        default:         state_d = ST_IDLE;
      endcase
    end
  end

  assign in_data_d = capture ? switches : in_data_q;

  // State and capture registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      in_data_q <= '0;
    end else begin
      state_q   <= state_d;
      in_data_q <= in_data_d;
    end
  end

  // Stall is gated by reset so the PC is never held while the block is being cleared
  assign insign   = reset & in_req & ~hlt & (state_q != ST_DONE);
  assign in_valid = (state_q == ST_DONE) & in_req & ~hlt;
  assign in_data  = in_data_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_input_stall_controller.sv
// Bench for input_stall_controller with a short debounce window.
module tb_input_stall_controller;

  localparam int DATA_W = 16;

  logic              clock;
  logic              reset;
  logic              in_req;
  logic              hlt;
  logic              button;
  logic [DATA_W-1:0] switches;
  logic              insign;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              busy;

  int n_tests  = 0;
  int n_failed = 0;
  int valid_cnt = 0;
  int ins_low_cnt = 0;
  logic [DATA_W-1:0] exp_q[$];

  input_stall_controller #(
    .DATA_W          (DATA_W),
    .DEBOUNCE_CYCLES (4),
    .BTN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_req   (in_req),
    .hlt      (hlt),
    .button   (button),
    .switches (switches),
    .insign   (insign),
    .in_data  (in_data),
    .in_valid (in_valid),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input int start, input string tag);
    for (int i = 0; i < 30 && valid_cnt == start; i++) tick(1);
    check_eq({tag, "_valid_pulses"}, 32'(valid_cnt - start), 32'd1);
  endtask

  // Scoreboard: every in_valid pulse must match the oldest expected word
  always @(negedge clock) begin
    if (reset && in_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) check_eq("spurious_valid", 32'd1, 32'd0);
      else check_eq("in_data_at_valid", 32'(in_data), 32'(exp_q.pop_front()));
    end
    if (reset && in_req && !hlt && !insign) ins_low_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [DATA_W-1:0] vals [2];
    vals[0] = 16'h0001;
    vals[1] = 16'h0002;

    reset = 1'b1; in_req = 1'b1; hlt = 1'b0; button = 1'b1; switches = 16'hBEEF;
    #1 reset = 1'b0;
    #1;
    check_eq("rst_insign",   32'(insign),   32'd0);
    check_eq("rst_in_valid", 32'(in_valid), 32'd0);
    check_eq("rst_in_data",  32'(in_data),  32'd0);
    check_eq("rst_busy",     32'(busy),     32'd0);
    tick(2);
    reset = 1'b1; in_req = 1'b0;
    tick(3);

    // Test 1: asynchronous reset while waiting for release
    in_req = 1'b1; switches = 16'hBEEF;
    tick(2);
    button = 1'b0;
    tick(10);
    check_eq("t1_busy_pre",    32'(busy),    32'd1);
    check_eq("t1_capture_pre", 32'(in_data), 32'hBEEF);
    #3 reset = 1'b0;
    #1;
    check_eq("t1_insign",   32'(insign),   32'd0);
    check_eq("t1_in_valid", 32'(in_valid), 32'd0);
    check_eq("t1_in_data",  32'(in_data),  32'd0);
    check_eq("t1_busy",     32'(busy),     32'd0);
    tick(2);
    reset = 1'b1; in_req = 1'b0; button = 1'b1;
    tick(3);

    // Test 2: clean press and release
    ins_low_cnt = 0;
    in_req = 1'b1; switches = 16'h00A5; exp_q.push_back(16'h00A5);
    tick(2);
    button = 1'b0;
    tick(10);
    s = valid_cnt;
    button = 1'b1;
    tick(10);
    wait_valid(s, "t2");
    check_eq("t2_insign_low_cycles", 32'(ins_low_cnt), 32'd1);
    in_req = 1'b0;
    tick(3);

    // Test 3: bouncing press yields a single capture
    in_req = 1'b1; switches = 16'hDEAD; exp_q.push_back(16'h5A5A);
    s = valid_cnt;
    for (int i = 0; i < 3; i++) begin
      button = 1'b0; tick(2);
      button = 1'b1; tick(2);
    end
    check_eq("t3_no_capture_bounce", 32'(in_data), 32'h00A5);
    check_eq("t3_busy",              32'(busy),    32'd1);
    switches = 16'h5A5A; button = 1'b0;
    tick(10);
    check_eq("t3_capture", 32'(in_data), 32'h5A5A);
    button = 1'b1;
    tick(10);
    wait_valid(s, "t3");
    in_req = 1'b0;
    tick(3);

    // Test 4: key already held when IN starts
    button = 1'b0;
    tick(10);
    in_req = 1'b1; switches = 16'h1234; exp_q.push_back(16'h1234);
    s = valid_cnt;
    tick(10);
    check_eq("t4_no_capture_held", 32'(in_data), 32'h5A5A);
    check_eq("t4_busy",            32'(busy),    32'd1);
    button = 1'b1;
    tick(10);
    check_eq("t4_no_capture_release", 32'(in_data), 32'h5A5A);
    button = 1'b0;
    tick(10);
    check_eq("t4_capture", 32'(in_data), 32'h1234);
    button = 1'b1;
    tick(10);
    wait_valid(s, "t4");
    in_req = 1'b0;
    tick(3);

    // Test 5: hlt in WAIT_RELEASE aborts without a valid pulse
    in_req = 1'b1; switches = 16'h7777;
    tick(2);
    button = 1'b0;
    tick(10);
    check_eq("t5_capture", 32'(in_data), 32'h7777);
    s = valid_cnt;
    hlt = 1'b1;
    #1;
    check_eq("t5_insign_hlt",   32'(insign),   32'd0);
    check_eq("t5_in_valid_hlt", 32'(in_valid), 32'd0);
    tick(1);
    check_eq("t5_busy_after_hlt", 32'(busy), 32'd0);
    hlt = 1'b0; in_req = 1'b0; button = 1'b1;
    tick(12);
    check_eq("t5_no_valid",  32'(valid_cnt - s), 32'd0);
    check_eq("t5_in_data",   32'(in_data),       32'h7777);

    // Test 6: two back-to-back IN instructions
    in_req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      switches = vals[k];
      exp_q.push_back(vals[k]);
      tick(2);
      button = 1'b0;
      tick(10);
      s = valid_cnt;
      button = 1'b1;
      tick(10);
      wait_valid(s, "t6");
    end
    in_req = 1'b0;
    tick(3);

    check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
